// File: rtl/ysyx_22050039_ifu_pkg.sv
// Shared types and constants for the ysyx_22050039 instruction fetch unit.
package ysyx_22050039_ifu_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam int          PC_STEP          = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22050039_ifu_pcgen.sv
// Fetch PC register: holds, steps by PC_STEP, or loads a redirect target.
module ysyx_22050039_ifu_pcgen
  import ysyx_22050039_ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic            advance_i,
  input  logic [XLEN-1:0] dnpc_i,
  output logic [XLEN-1:0] fetch_pc_o
);

  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_d;

  // A redirect always wins over the sequential step.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = dnpc_i;
    end else if (advance_i) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign fetch_pc_o = fetch_pc_q;

endmodule

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: one outstanding imem request, held word handed to decode.
// Build option IFU_MISALIGN_CHK_EN: a misaligned redirect traps into a sticky ERR state.
module ysyx_22050039_ifu
  import ysyx_22050039_ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0]
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_wen,
  input  logic [XLEN-1:0]     dnpc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INST_LEN-1:0] imem_resp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     pc,
  output logic                fetch_err,
  output ifu_state_e          dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high; valid never depends on ready, and payload stays stable while valid
  // is high and ready is low (except that a redirect may retarget a stalled request).

  ifu_state_e          state_q;
  logic                kill_q;
  logic [INST_LEN-1:0] inst_q;
  logic [XLEN-1:0]     pc_q;
  logic [XLEN-1:0]     fetch_pc;
  logic [XLEN-1:0]     dnpc_eff;
  logic                misalign;
  logic                redirect;
  logic                advance;
  logic                req_fire;

`ifdef IFU_MISALIGN_CHK_EN
  assign dnpc_eff = dnpc;
  assign misalign = pc_wen && (dnpc[1:0] != 2'b00);
`else
  assign dnpc_eff = dnpc & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign misalign = 1'b0;
`endif

  assign redirect = pc_wen && (state_q != S_ERR);
  assign advance  = (state_q == S_HOLD) && inst_ready;
  assign req_fire = (state_q == S_REQ) && imem_req_ready;

  ysyx_22050039_ifu_pcgen #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC)
  ) u_pcgen (
    .clk       (clk),
    .rst       (rst),
    .redirect_i(redirect),
    .advance_i (advance),
    .dnpc_i    (dnpc_eff),
    .fetch_pc_o(fetch_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
      inst_q  <= INST_LEN'(NOP_INST);
      pc_q    <= RESET_PC;
    end else if (misalign && (state_q != S_ERR)) begin
      state_q <= S_ERR;
      kill_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (req_fire) begin
            state_q <= S_WAIT;
            kill_q  <= pc_wen;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            // Wrong-path word (earlier or same-cycle redirect) is discarded.
            if (kill_q || pc_wen) begin
              kill_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              inst_q  <= imem_resp_data;
              pc_q    <= fetch_pc;
              state_q <= S_HOLD;
            end
          end else if (pc_wen) begin
            kill_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (inst_ready || pc_wen) begin
            state_q <= S_REQ;
          end
        end
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = fetch_pc;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign dbg_state      = state_q;

`ifdef IFU_MISALIGN_CHK_EN
  assign fetch_err = (state_q == S_ERR);
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// Directed bench for ysyx_22050039_ifu: 1/2-cycle memory model and a delivery scoreboard.
module tb_ysyx_22050039_ifu;
  import ysyx_22050039_ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_wen;
  logic [63:0] dnpc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        fetch_err;
  ifu_state_e  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_fire   = 0;
  int n_deliv  = 0;
  int mem_delay = 1;
  int pend_cnt  = 0;
  logic [63:0] pend_addr = '0;
  logic        inj_resp  = 1'b0;
  logic [95:0] exp_q[$];
  logic [95:0] exp_e;
  int d0;
  int f0;

  ysyx_22050039_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .pc_wen         (pc_wen),
    .dnpc           (dnpc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .fetch_err      (fetch_err),
    .dbg_state      (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_for(input logic [63:0] a);
    return 32'h0010_0093 + (a[31:0] - 32'h8000_0000);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_deliv(input logic [63:0] a);
    exp_q.push_back({a, word_for(a)});
  endtask

  // Memory model and delivery scoreboard
  always begin
    @(negedge clk);
    if (!rst && imem_req_valid && imem_req_ready) begin
      pend_cnt  = mem_delay;
      pend_addr = imem_req_addr;
      n_fire++;
    end
    if (!rst && inst_valid && inst_ready) begin
      n_deliv++;
      if (exp_q.size() == 0) begin
        check_eq("deliv_unexpected", 64'd1, 64'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check_eq("deliv_pc", pc, exp_e[95:32]);
        check_eq("deliv_inst", {32'h0, inst}, {32'h0, exp_e[31:0]});
      end
    end
    @(posedge clk);
    #1;
    imem_resp_valid = inj_resp;
    imem_resp_data  = inj_resp ? 32'hDEAD_BEEF : 32'h0;
    if (rst) begin
      pend_cnt = 0;
    end else if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = word_for(pend_addr);
      end
    end
  end

  initial begin
    rst = 1'b1; pc_wen = 1'b0; dnpc = '0; imem_req_ready = 1'b1;
    inst_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    step(); step();
    check_eq("rst_state", 64'(dbg_state), 64'(S_IDLE));
    check_eq("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
    check_eq("rst_inst", 64'(inst), 64'h13);
    check_eq("rst_pc", pc, 64'h8000_0000);
    check_eq("rst_fetch_err", 64'(fetch_err), 64'd0);

    // First fetch after release
    rst = 1'b0;
    step();
    check_eq("t1_state", 64'(dbg_state), 64'(S_REQ));
    check_eq("t1_req_valid", 64'(imem_req_valid), 64'd1);
    check_eq("t1_req_addr", imem_req_addr, 64'h8000_0000);
    step();
    check_eq("t1_wait_req_valid", 64'(imem_req_valid), 64'd0);
    check_eq("t1_wait_inst_valid", 64'(inst_valid), 64'd0);
    step();
    check_eq("t1_inst_valid", 64'(inst_valid), 64'd1);
    check_eq("t1_inst", 64'(inst), 64'h0010_0093);
    check_eq("t1_pc", pc, 64'h8000_0000);

    // Decode back-pressure in HOLD
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t2_hold_valid", 64'(inst_valid), 64'd1);
      check_eq("t2_hold_inst", 64'(inst), 64'h0010_0093);
      check_eq("t2_hold_pc", pc, 64'h8000_0000);
      check_eq("t2_no_req", 64'(imem_req_valid), 64'd0);
    end
    push_deliv(64'h8000_0000);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check_eq("t2_req_valid", 64'(imem_req_valid), 64'd1);
    check_eq("t2_req_addr", imem_req_addr, 64'h8000_0004);
    check_eq("t2_inst_valid", 64'(inst_valid), 64'd0);

    // Redirect in WAIT, same cycle as the response
    step();
    check_eq("t3_state", 64'(dbg_state), 64'(S_WAIT));
    pc_wen = 1'b1; dnpc = 64'h8000_0100;
    step();
    pc_wen = 1'b0;
    check_eq("t3_drop_state", 64'(dbg_state), 64'(S_REQ));
    check_eq("t3_drop_valid", 64'(inst_valid), 64'd0);
    check_eq("t3_req_addr", imem_req_addr, 64'h8000_0100);
    step(); step();
    check_eq("t3_inst_valid", 64'(inst_valid), 64'd1);
    check_eq("t3_pc", pc, 64'h8000_0100);

    // Redirect in HOLD with inst_ready high: no +4
    push_deliv(64'h8000_0100);
    inst_ready = 1'b1; pc_wen = 1'b1; dnpc = 64'h8000_0040;
    step();
    inst_ready = 1'b0; pc_wen = 1'b0;
    check_eq("t4_req_addr", imem_req_addr, 64'h8000_0040);
    check_eq("t4_inst_valid", 64'(inst_valid), 64'd0);

    // Request stall, then redirect during the stall
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t5_stall_valid", 64'(imem_req_valid), 64'd1);
      check_eq("t5_stall_addr", imem_req_addr, 64'h8000_0040);
    end
    pc_wen = 1'b1; dnpc = 64'h8000_0080;
    step();
    pc_wen = 1'b0;
    check_eq("t5_redir_valid", 64'(imem_req_valid), 64'd1);
    check_eq("t5_redir_addr", imem_req_addr, 64'h8000_0080);
    imem_req_ready = 1'b1;
    step(); step();
    check_eq("t5_pc", pc, 64'h8000_0080);

    // Redirect in REQ on the firing cycle: old word killed
    push_deliv(64'h8000_0080);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check_eq("t6_req_addr", imem_req_addr, 64'h8000_0084);
    pc_wen = 1'b1; dnpc = 64'h8000_0200;
    step();
    pc_wen = 1'b0;
    check_eq("t6_state_wait", 64'(dbg_state), 64'(S_WAIT));
    step();
    check_eq("t6_state_req", 64'(dbg_state), 64'(S_REQ));
    check_eq("t6_inst_valid", 64'(inst_valid), 64'd0);
    check_eq("t6_req_addr2", imem_req_addr, 64'h8000_0200);
    step(); step();
    check_eq("t6_pc", pc, 64'h8000_0200);

    // Redirect in WAIT before a 2-cycle response: kill flag drops it later
    mem_delay = 2;
    push_deliv(64'h8000_0200);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check_eq("t7_req_addr", imem_req_addr, 64'h8000_0204);
    step();
    pc_wen = 1'b1; dnpc = 64'h8000_0300;
    step();
    pc_wen = 1'b0;
    check_eq("t7_state_wait", 64'(dbg_state), 64'(S_WAIT));
    step();
    check_eq("t7_state_req", 64'(dbg_state), 64'(S_REQ));
    check_eq("t7_inst_valid", 64'(inst_valid), 64'd0);
    check_eq("t7_req_addr2", imem_req_addr, 64'h8000_0300);
    mem_delay = 1;

    // Reset mid-WAIT, stray response in IDLE, redirect in IDLE
    step();
    rst = 1'b1;
    #1;
    check_eq("t8_rst_state", 64'(dbg_state), 64'(S_IDLE));
    check_eq("t8_rst_req_valid", 64'(imem_req_valid), 64'd0);
    check_eq("t8_rst_inst", 64'(inst), 64'h13);
    check_eq("t8_rst_pc", pc, 64'h8000_0000);
    inj_resp = 1'b1;
    step();
    inj_resp = 1'b0;
    rst = 1'b0; pc_wen = 1'b1; dnpc = 64'h8000_0400;
    step();
    pc_wen = 1'b0;
    check_eq("t8_state", 64'(dbg_state), 64'(S_REQ));
    check_eq("t8_req_addr", imem_req_addr, 64'h8000_0400);
    check_eq("t8_inst_nop", 64'(inst), 64'h13);
    step(); step();
    check_eq("t8_pc", pc, 64'h8000_0400);

    // Throughput: one instruction every three cycles
    push_deliv(64'h8000_0400);
    push_deliv(64'h8000_0404);
    push_deliv(64'h8000_0408);
    d0 = n_deliv;
    inst_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    inst_ready = 1'b0;
    check_eq("t9_deliv_count", 64'(n_deliv - d0), 64'd3);
    check_eq("t9_req_addr", imem_req_addr, 64'h8000_040C);

    // Wrap of the fetch PC
    pc_wen = 1'b1; dnpc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    pc_wen = 1'b0;
    step();
    check_eq("t10_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(); step();
    check_eq("t10_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    push_deliv(64'hFFFF_FFFF_FFFF_FFFC);
    inst_ready = 1'b1; imem_req_ready = 1'b0;
    step();
    inst_ready = 1'b0;
    check_eq("t10_wrap_addr", imem_req_addr, 64'h0);

    // Misaligned redirect
    f0 = n_fire;
    pc_wen = 1'b1; dnpc = 64'h8000_0002;
    step();
    pc_wen = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    check_eq("t11_fetch_err", 64'(fetch_err), 64'd1);
    check_eq("t11_state", 64'(dbg_state), 64'(S_ERR));
    imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t11_no_req", 64'(imem_req_valid), 64'd0);
      check_eq("t11_no_inst", 64'(inst_valid), 64'd0);
      check_eq("t11_err_sticky", 64'(fetch_err), 64'd1);
    end
    check_eq("t11_fire_count", 64'(n_fire - f0), 64'd0);
    rst = 1'b1;
    #1;
    check_eq("t11_err_cleared", 64'(fetch_err), 64'd0);
    step();
    rst = 1'b0;
`else
    check_eq("t11_fetch_err", 64'(fetch_err), 64'd0);
    check_eq("t11_req_valid", 64'(imem_req_valid), 64'd1);
    check_eq("t11_req_addr", imem_req_addr, 64'h8000_0000);
    check_eq("t11_fire_count", 64'(n_fire - f0), 64'd0);
`endif

    step();
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
